// File: rtl/sample_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : sample_buffer_writer
// Description : Captures BUFFER_DEPTH samples from a free-running sample
//               stream into a sync RAM, then serves the block in write order
//               on a valid/ready read port through a 2-entry prefetch skid.
//               Optional macro SAMPLE_BUF_OVERRUN_CNT_EN adds a saturating
//               dropped-sample counter on overrun_count_o.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_buffer_writer #(
  parameter int BUFFER_DEPTH      = 256,
  parameter int DATA_WIDTH        = 24,
  parameter int OVERRUN_CNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         capture_en_i,
  input  logic [DATA_WIDTH-1:0]        sample_data_i,
  input  logic                         sample_valid_i,
  output logic                         ram_buffer_ready_o,
  output logic [DATA_WIDTH-1:0]        ram_read_data_o,
  output logic                         ram_read_valid_o,
  input  logic                         ram_read_ready_i,
  output logic [OVERRUN_CNT_WIDTH-1:0] overrun_count_o,
  output logic [1:0]                   state_o
);

  localparam int              c_ADDR_W    = $clog2(BUFFER_DEPTH);
  localparam logic [1:0]      c_IDLE      = 2'd0;
  localparam logic [1:0]      c_FILL      = 2'd1;
  localparam logic [1:0]      c_DRAIN     = 2'd2;
  localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(BUFFER_DEPTH - 1);
  localparam logic [c_ADDR_W:0]   c_LAST_XFER = (c_ADDR_W + 1)'(BUFFER_DEPTH - 1);
  localparam logic [c_ADDR_W:0]   c_DEPTH     = (c_ADDR_W + 1)'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic                  r_buf_ready;
  logic [c_ADDR_W-1:0]   r_wr_ptr;
  logic [c_ADDR_W:0]     r_rd_cnt;      // reads issued to the RAM this block
  logic [c_ADDR_W:0]     r_xfer_cnt;    // completed read-port transfers
  logic                  r_inflight;    // RAM read issued last cycle, r_ram_q valid now
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_skid_valid;

  logic                  w_write;
  logic                  w_pop;
  logic                  w_last_xfer;
  logic [2:0]            w_level;
  logic                  w_issue;

  assign w_write     = (r_state == c_FILL) && sample_valid_i;
  assign w_pop       = r_out_valid && ram_read_ready_i;
  assign w_last_xfer = w_pop && (r_xfer_cnt == c_LAST_XFER);
  // Entries that will be held after this cycle, counting the read in flight.
  // A new read is only issued if its data is guaranteed a slot next cycle.
  assign w_level     = {2'b00, r_out_valid} + {2'b00, r_skid_valid}
                     + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == c_DRAIN) && (r_rd_cnt < c_DEPTH) && (w_level < 3'd2);

  // Next-state decode for the IDLE / FILL / DRAIN sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (capture_en_i) w_state_next = c_FILL;
      c_FILL:  if (w_write && (r_wr_ptr == c_LAST_ADDR)) w_state_next = c_DRAIN;
      c_DRAIN: if (w_last_xfer) w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  // State register, registered buffer-ready flag and write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= c_IDLE;
      r_buf_ready <= 1'b0;
      r_wr_ptr    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_buf_ready <= (w_state_next == c_DRAIN);
      if (r_state == c_IDLE) begin
        r_wr_ptr <= '0;
      end else if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Sample RAM: write during FILL, one-cycle registered read during DRAIN.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= sample_data_i;
    end
    if (w_issue) begin
      r_ram_q <= r_mem[r_rd_cnt[c_ADDR_W-1:0]];
    end
  end

  // Read engine: issue tracking, transfer count and the 2-entry output skid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_cnt     <= '0;
      r_xfer_cnt   <= '0;
      r_inflight   <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else if ((r_state != c_DRAIN) || w_last_xfer) begin
      r_rd_cnt     <= '0;
      r_xfer_cnt   <= '0;
      r_inflight   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (w_pop) begin
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
      if (!r_out_valid || w_pop) begin
        // Output slot frees up: oldest entry (skid first, then RAM) moves in.
        if (r_skid_valid) begin
          r_out_data   <= r_skid_data;
          r_out_valid  <= 1'b1;
          r_skid_valid <= r_inflight;
          if (r_inflight) begin
            r_skid_data <= r_ram_q;
          end
        end else begin
          r_out_valid <= r_inflight;
          if (r_inflight) begin
            r_out_data <= r_ram_q;
          end
        end
      end else if (r_inflight) begin
        // Output stalled: park the arriving RAM word in the skid entry.
        r_skid_data  <= r_ram_q;
        r_skid_valid <= 1'b1;
      end
    end
  end

`ifdef SAMPLE_BUF_OVERRUN_CNT_EN
  logic [OVERRUN_CNT_WIDTH-1:0] r_overrun;
  logic                         w_drop;

  assign w_drop = sample_valid_i && ((r_state == c_IDLE) || (r_state == c_DRAIN));

  // Saturating count of samples that arrived while no write was possible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overrun <= '0;
    end else if (w_drop && (r_overrun != {OVERRUN_CNT_WIDTH{1'b1}})) begin
      r_overrun <= r_overrun + 1'b1;
    end
  end

  assign overrun_count_o = r_overrun;
`else
  assign overrun_count_o = '0;
`endif

  assign ram_buffer_ready_o = r_buf_ready;
  assign ram_read_data_o    = r_out_data;
  assign ram_read_valid_o   = r_out_valid;
  assign state_o            = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sample_buffer_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_buffer_writer
// Description : Self-checking bench for sample_buffer_writer (DEPTH = 8).
//               Expected block contents are kept in queues; overrun count is
//               tracked from the strobes the bench drives outside FILL.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_buffer_writer;

  localparam int DEPTH = 8;
  localparam int DW    = 24;
  localparam int OW    = 16;

  typedef logic [DW-1:0] sample_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          capture_en_i = 1'b0;
  logic [DW-1:0] sample_data_i = '0;
  logic          sample_valid_i = 1'b0;
  logic          ram_buffer_ready_o;
  logic [DW-1:0] ram_read_data_o;
  logic          ram_read_valid_o;
  logic          ram_read_ready_i = 1'b0;
  logic [OW-1:0] overrun_count_o;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;
  int exp_overrun = 0;

  sample_buffer_writer #(
    .BUFFER_DEPTH      (DEPTH),
    .DATA_WIDTH        (DW),
    .OVERRUN_CNT_WIDTH (OW)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .capture_en_i       (capture_en_i),
    .sample_data_i      (sample_data_i),
    .sample_valid_i     (sample_valid_i),
    .ram_buffer_ready_o (ram_buffer_ready_o),
    .ram_read_data_o    (ram_read_data_o),
    .ram_read_valid_o   (ram_read_valid_o),
    .ram_read_ready_i   (ram_read_ready_i),
    .overrun_count_o    (overrun_count_o),
    .state_o            (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; observe and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // A strobe outside FILL is a dropped sample.
  function automatic void note_drop();
    if (exp_overrun < 65535) exp_overrun++;
  endfunction

  function automatic logic [OW-1:0] exp_ovr();
`ifdef SAMPLE_BUF_OVERRUN_CNT_EN
    return OW'(exp_overrun);
`else
    return '0;
`endif
  endfunction

  // Fill one block from IDLE: one sample every 'gap' cycles.
  task automatic fill_block(input sample_t d[$], input int gap);
    capture_en_i = 1'b1;
    step();
    checks++;
    if (state_o !== 2'd1) begin
      errors++; $display("FAIL fill_enter: state %0d expected 1", state_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int g = 1; g < gap; g++) begin
        capture_en_i = 1'($urandom_range(0, 1));
        step();
      end
      capture_en_i   = 1'($urandom_range(0, 1));
      sample_valid_i = 1'b1;
      sample_data_i  = d[i];
      step();
      sample_valid_i = 1'b0;
      if (i < DEPTH - 1) begin
        checks++;
        if (state_o !== 2'd1 || ram_buffer_ready_o !== 1'b0) begin
          errors++; $display("FAIL fill_hold: state %0d rdy %0b expected 1/0", state_o, ram_buffer_ready_o);
        end
      end
    end
    capture_en_i = 1'b0;
    checks++;
    if (state_o !== 2'd2 || ram_buffer_ready_o !== 1'b1 || ram_read_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_enter: state %0d rdy %0b valid %0b expected 2/1/0",
               state_o, ram_buffer_ready_o, ram_read_valid_o);
    end
  endtask

  // Drain one block starting at the first DRAIN cycle. rdy_mode 0: ready held
  // high; 1: random ready with long stalls. inject: strobe on DRAIN cycle k.
  task automatic drain_block(input sample_t d[$], input int rdy_mode, input int inject, input bit b2b);
    int      k = 0, got = 0, first = -1, last = -1, stall = 0;
    bit      pv = 0, pt = 0, done = 0;
    sample_t pd = '0;
    capture_en_i = b2b;
    while (!done && k < 400) begin
      if (rdy_mode == 0) begin
        ram_read_ready_i = 1'b1;
      end else if (stall > 0) begin
        ram_read_ready_i = 1'b0; stall--;
      end else if ($urandom_range(0, 9) == 0) begin
        ram_read_ready_i = 1'b0; stall = $urandom_range(4, 12);
      end else begin
        ram_read_ready_i = 1'($urandom_range(0, 1));
      end
      if (k < 8 && inject[k]) begin
        sample_valid_i = 1'b1;
        sample_data_i  = sample_t'($urandom);
        note_drop();
      end
      checks++;
      if (ram_buffer_ready_o !== 1'b1 || state_o !== 2'd2) begin
        errors++; $display("FAIL drain_ready: cycle %0d rdy %0b state %0d expected 1/2", k, ram_buffer_ready_o, state_o);
      end
      if (pv && !pt) begin
        checks++;
        if (ram_read_valid_o !== 1'b1 || ram_read_data_o !== pd) begin
          errors++;
          $display("FAIL stall_hold: cycle %0d valid %0b data %06h expected 1/%06h", k, ram_read_valid_o, ram_read_data_o, pd);
        end
      end
      if (rdy_mode == 0 && first >= 0) begin
        checks++;
        if (ram_read_valid_o !== 1'b1) begin
          errors++; $display("FAIL no_bubble: cycle %0d valid %0b expected 1", k, ram_read_valid_o);
        end
      end
      if (ram_read_valid_o === 1'b1) begin
        if (first < 0) first = k;
        if (ram_read_ready_i) begin
          checks++;
          if (ram_read_data_o !== d[got]) begin
            errors++; $display("FAIL read_data[%0d]: got %06h expected %06h", got, ram_read_data_o, d[got]);
          end
          got++;
          last = k;
          if (got == DEPTH) done = 1;
        end
      end
      pv = ram_read_valid_o;
      pt = ram_read_valid_o && ram_read_ready_i;
      pd = ram_read_data_o;
      step();
      sample_valid_i = 1'b0;
      k++;
    end
    ram_read_ready_i = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL drain_timeout: transfers %0d expected %0d", got, DEPTH);
    end
    checks++;
    if (first < 0 || first > 2) begin
      errors++; $display("FAIL first_valid: cycle %0d expected <= 2", first);
    end
    if (rdy_mode == 0) begin
      checks++;
      if (last > DEPTH + 1) begin
        errors++; $display("FAIL drain_latency: last transfer cycle %0d expected <= %0d", last, DEPTH + 1);
      end
    end
    checks++;
    if (ram_read_valid_o !== 1'b0 || ram_buffer_ready_o !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL drain_exit: valid %0b rdy %0b state %0d expected 0/0/0",
               ram_read_valid_o, ram_buffer_ready_o, state_o);
    end
    checks++;
    if (overrun_count_o !== exp_ovr()) begin
      errors++; $display("FAIL overrun_drain: got %0d expected %0d", overrun_count_o, exp_ovr());
    end
  endtask

  task automatic rand_block(output sample_t d[$]);
    d = {};
    for (int i = 0; i < DEPTH; i++) d.push_back(sample_t'($urandom));
  endtask

  task automatic test_reset();
    step(); step();
    #3 rst_ni = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd0 || ram_buffer_ready_o !== 1'b0 || ram_read_valid_o !== 1'b0 ||
        ram_read_data_o !== '0 || overrun_count_o !== '0) begin
      errors++;
      $display("FAIL reset: state %0d rdy %0b valid %0b data %06h ovr %0d expected all 0",
               state_o, ram_buffer_ready_o, ram_read_valid_o, ram_read_data_o, overrun_count_o);
    end
    step(); step();
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    checks++;
    if (state_o !== 2'd0) begin
      errors++; $display("FAIL reset_release: state %0d expected 0", state_o);
    end
  endtask

  task automatic test_idle_drop();
    capture_en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_valid_i = 1'b1;
      sample_data_i  = sample_t'($urandom);
      note_drop();
      step();
      sample_valid_i = 1'b0;
      step();
      checks++;
      if (state_o !== 2'd0 || ram_buffer_ready_o !== 1'b0) begin
        errors++; $display("FAIL idle_hold: state %0d rdy %0b expected 0/0", state_o, ram_buffer_ready_o);
      end
    end
    checks++;
    if (overrun_count_o !== exp_ovr()) begin
      errors++; $display("FAIL overrun_idle: got %0d expected %0d", overrun_count_o, exp_ovr());
    end
  endtask

  task automatic test_basic();
    sample_t d[$];
    d = {};
    for (int i = 1; i <= DEPTH; i++) d.push_back(sample_t'(i));
    fill_block(d, 3);
    drain_block(d, 0, 0, 1'b0);
  endtask

  task automatic test_stall_random();
    sample_t d[$];
    rand_block(d);
    d[3] = sample_t'(-5);
    fill_block(d, 1);
    drain_block(d, 1, 8'b0010_0101, 1'b0);
  endtask

  task automatic test_back_to_back();
    sample_t d[$];
    sample_t e[$];
    rand_block(d);
    rand_block(e);
    fill_block(d, 2);
    drain_block(d, 0, 8'b0001_1010, 1'b1);
    fill_block(e, 1);
    drain_block(e, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    sample_t d[$];
    sample_t e[$];
    rand_block(d);
    rand_block(e);
    fill_block(d, 2);
    ram_read_ready_i = 1'b0;
    step(); step(); step();
    checks++;
    if (ram_read_valid_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got %0b expected 1", ram_read_valid_o);
    end
    #3 rst_ni = 1'b0;
    exp_overrun = 0;
    #1;
    checks++;
    if (state_o !== 2'd0 || ram_buffer_ready_o !== 1'b0 || ram_read_valid_o !== 1'b0 ||
        ram_read_data_o !== '0 || overrun_count_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_drain: state %0d rdy %0b valid %0b data %06h ovr %0d expected all 0",
               state_o, ram_buffer_ready_o, ram_read_valid_o, ram_read_data_o, overrun_count_o);
    end
    step();
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    fill_block(e, 1);
    drain_block(e, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_drop();
    test_basic();
    test_stall_random();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
